// File: rtl/axi_out_isolate_ctrl_pkg.sv
// Shared types and default sizing for the outbound AXI isolation controller.
package axi_out_isolate_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StDrain   = 2'd1,
        StIso     = 2'd2,
        StRelease = 2'd3
    } iso_state_e;

    // Also used by the subsystem wrapper to size the isolation stage NumPending.
    localparam int IsoMaxTrans      = 8;
    localparam int IsoTimeoutCycles = 1024;

endpackage

// File: rtl/axi_out_isolate_ctrl_outstanding_cnt.sv
// Saturating up/down burst counter; o_err flags an overflow or underflow attempt this cycle.
module iso_outstanding_cnt
    import axi_out_isolate_ctrl_pkg::*;
#(
    parameter int MaxTrans = IsoMaxTrans,
    parameter int CntW     = $clog2(MaxTrans + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            i_inc,
    input  logic            i_dec,
    output logic [CntW-1:0] o_count,
    output logic            o_err
);

    localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);

    logic [CntW-1:0] r_count;
    logic            w_up;
    logic            w_down;

    // A simultaneous open and close leaves the count unchanged.
    assign w_up   = i_inc & ~i_dec;
    assign w_down = i_dec & ~i_inc;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (w_up && (r_count != CntMax)) begin
            r_count <= r_count + CntW'(1);
        end else if (w_down && (r_count != '0)) begin
            r_count <= r_count - CntW'(1);
        end
    end

    assign o_err   = (w_up && (r_count == CntMax)) || (w_down && (r_count == '0));
    assign o_count = r_count;

endmodule

// File: rtl/axi_out_isolate_ctrl.sv
// Sequences the outbound AXI isolation stage: drain open bursts, isolate, acknowledge, release.
module axi_out_isolate_ctrl
    import axi_out_isolate_ctrl_pkg::*;
#(
    parameter int MaxTrans      = IsoMaxTrans,
    parameter int TimeoutCycles = IsoTimeoutCycles,
    parameter bit ResetIsolated = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           iso_req_i,
    output logic                           iso_ack_o,
    output logic                           axi_isolate_o,
    input  logic                           axi_isolated_i,
    input  logic                           aw_hs_i,
    input  logic                           b_hs_i,
    input  logic                           ar_hs_i,
    input  logic                           r_last_hs_i,
    input  logic                           clr_err_i,
    output logic [$clog2(MaxTrans+1)-1:0]  wr_outstanding_o,
    output logic [$clog2(MaxTrans+1)-1:0]  rd_outstanding_o,
    output logic [1:0]                     state_o,
    output logic                           timeout_irq_o,
    output logic                           err_o
);

    localparam int                CntW       = $clog2(MaxTrans + 1);
    localparam int                TimerW     = $clog2(TimeoutCycles);
    localparam logic [TimerW-1:0] TimerLast  = TimerW'(TimeoutCycles - 1);
    localparam iso_state_e        ResetState = ResetIsolated ? StIso : StRun;

    iso_state_e        r_state;
    iso_state_e        w_stateNext;
    logic [TimerW-1:0] r_timer;
    logic [TimerW-1:0] w_timerInc;
    logic              r_irq;
    logic              r_err;
    logic              w_timeoutHit;
    logic              w_drained;
    logic              w_wrErr;
    logic              w_rdErr;
    logic [CntW-1:0]   w_wrCount;
    logic [CntW-1:0]   w_rdCount;

    iso_outstanding_cnt #(.MaxTrans(MaxTrans), .CntW(CntW)) u_wr_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_inc   (aw_hs_i),
        .i_dec   (b_hs_i),
        .o_count (w_wrCount),
        .o_err   (w_wrErr)
    );

    iso_outstanding_cnt #(.MaxTrans(MaxTrans), .CntW(CntW)) u_rd_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_inc   (ar_hs_i),
        .i_dec   (r_last_hs_i),
        .o_count (w_rdCount),
        .o_err   (w_rdErr)
    );

    assign w_drained  = axi_isolated_i && (w_wrCount == '0) && (w_rdCount == '0);
    assign w_timerInc = r_timer + TimerW'(1);

    // The timeout fires on the step onto TimerLast, so the pulse lines up with the timer showing it;
    // once parked there the timer no longer steps, giving one pulse per drain entry.
    always_comb begin
        w_stateNext  = r_state;
        w_timeoutHit = 1'b0;
        case (r_state)
            StRun: begin
                if (iso_req_i) w_stateNext = StDrain;
            end
            StDrain: begin
                if (!iso_req_i) begin
                    w_stateNext = StRelease;
                end else if (w_drained) begin
                    w_stateNext = StIso;
                end else if (w_timerInc == TimerLast) begin
                    w_timeoutHit = 1'b1;
                end
            end
            StIso: begin
                if (!iso_req_i) w_stateNext = StRelease;
            end
            StRelease: begin
                if (!axi_isolated_i) w_stateNext = iso_req_i ? StDrain : StRun;
            end
            default: w_stateNext = ResetState;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ResetState;
            r_timer <= '0;
            r_irq   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_irq   <= w_timeoutHit;
            if ((r_state == StDrain) && (w_stateNext == StDrain)) begin
                if (r_timer != TimerLast) r_timer <= w_timerInc;
            end else begin
                r_timer <= '0;
            end
            if (w_timeoutHit || w_wrErr || w_rdErr) begin
                r_err <= 1'b1;
            end else if (clr_err_i) begin
                r_err <= 1'b0;
            end
        end
    end

    assign axi_isolate_o    = (r_state == StDrain) || (r_state == StIso);
    assign iso_ack_o        = (r_state == StIso);
    assign state_o          = r_state;
    assign timeout_irq_o    = r_irq;
    assign err_o            = r_err;
    assign wr_outstanding_o = w_wrCount;
    assign rd_outstanding_o = w_rdCount;

endmodule

// File: tb/tb_axi_out_isolate_ctrl.sv
// Directed bench for axi_out_isolate_ctrl with MaxTrans=8, TimeoutCycles=16, ResetIsolated=1.
module tb_axi_out_isolate_ctrl;

    logic       clk = 1'b0;
    logic       rstN;
    logic       isoReq;
    logic       isoAck;
    logic       axiIsolate;
    logic       axiIsolated;
    logic       awHs;
    logic       bHs;
    logic       arHs;
    logic       rLastHs;
    logic       clrErr;
    logic [3:0] wrOut;
    logic [3:0] rdOut;
    logic [1:0] stateOut;
    logic       timeoutIrq;
    logic       errOut;

    int checks = 0;
    int errors = 0;

    axi_out_isolate_ctrl #(
        .MaxTrans      (8),
        .TimeoutCycles (16),
        .ResetIsolated (1'b1)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rstN),
        .iso_req_i        (isoReq),
        .iso_ack_o        (isoAck),
        .axi_isolate_o    (axiIsolate),
        .axi_isolated_i   (axiIsolated),
        .aw_hs_i          (awHs),
        .b_hs_i           (bHs),
        .ar_hs_i          (arHs),
        .r_last_hs_i      (rLastHs),
        .clr_err_i        (clrErr),
        .wr_outstanding_o (wrOut),
        .rd_outstanding_o (rdOut),
        .state_o          (stateOut),
        .timeout_irq_o    (timeoutIrq),
        .err_o            (errOut)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic stepCycle(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic req, input logic isolated, input logic aw, input logic b,
                                 input logic ar, input logic rl, input logic clr);
        isoReq      = req;
        axiIsolated = isolated;
        awHs        = aw;
        bHs         = b;
        arHs        = ar;
        rLastHs     = rl;
        clrErr      = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle(2);

        // Reset leaves the stage isolated and acknowledged
        checkOutput("rst_state", stateOut, 2);
        checkOutput("rst_ack", isoAck, 1);
        checkOutput("rst_isolate", axiIsolate, 1);
        checkOutput("rst_wr", wrOut, 0);
        checkOutput("rst_rd", rdOut, 0);
        checkOutput("rst_err", errOut, 0);
        checkOutput("rst_irq", timeoutIrq, 0);
        rstN = 1'b1;

        // No request held: ISO -> RELEASE, wait for isolated to drop, then RUN
        stepCycle();
        checkOutput("rel_state", stateOut, 3);
        checkOutput("rel_isolate", axiIsolate, 0);
        checkOutput("rel_ack", isoAck, 0);
        stepCycle();
        checkOutput("rel_hold", stateOut, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("run_state", stateOut, 0);

        // Three writes open, then drain them
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle(3);
        checkOutput("wr_three", wrOut, 3);
        checkOutput("run_hold", stateOut, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("drain_state", stateOut, 1);
        checkOutput("drain_isolate", axiIsolate, 1);
        checkOutput("drain_ack", isoAck, 0);
        checkOutput("drain_wr", wrOut, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycle(3);
        checkOutput("drain_wr0", wrOut, 0);
        checkOutput("drain_wr0_state", stateOut, 1);
        checkOutput("drain_wr0_ack", isoAck, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("iso_ack", isoAck, 1);
        checkOutput("iso_state", stateOut, 2);
        checkOutput("iso_err", errOut, 0);

        // Back to RUN
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("iso_rel", stateOut, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("rel_run", stateOut, 0);

        // Timeout: one read held open through the drain
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("rd_one", rdOut, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("to_drain", stateOut, 1);
        checkOutput("to_irq_c1", timeoutIrq, 0);
        for (int c = 2; c <= 15; c++) begin
            stepCycle();
            checkOutput($sformatf("to_irq_c%0d", c), timeoutIrq, 0);
        end
        stepCycle();
        checkOutput("to_irq_c16", timeoutIrq, 1);
        checkOutput("to_err_c16", errOut, 1);
        checkOutput("to_state_c16", stateOut, 1);
        for (int c = 17; c <= 24; c++) begin
            stepCycle();
            checkOutput($sformatf("to_irq_c%0d", c), timeoutIrq, 0);
        end
        checkOutput("to_still_drain", stateOut, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("to_rd0", rdOut, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("to_iso", stateOut, 2);
        checkOutput("to_ack", isoAck, 1);
        checkOutput("to_err_sticky", errOut, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("clr_err", errOut, 0);

        // Counter boundaries
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle(2);
        checkOutput("wr_two", wrOut, 2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("wr_both", wrOut, 2);
        checkOutput("wr_both_err", errOut, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycle(2);
        checkOutput("wr_zero", wrOut, 0);
        checkOutput("wr_zero_err", errOut, 0);
        stepCycle();
        checkOutput("underflow_wr", wrOut, 0);
        checkOutput("underflow_err", errOut, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("clr_err2", errOut, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle(8);
        checkOutput("wr_max", wrOut, 8);
        checkOutput("wr_max_err", errOut, 0);
        stepCycle();
        checkOutput("overflow_wr", wrOut, 8);
        checkOutput("overflow_err", errOut, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycle(8);
        checkOutput("wr_back0", wrOut, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("set_beats_clr", errOut, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("clr_err3", errOut, 0);

        // Abort a drain at timer=5, then reset in the middle of another drain
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("ab_run", stateOut, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle(6);
        checkOutput("ab_drain", stateOut, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("ab_release", stateOut, 3);
        checkOutput("ab_irq", timeoutIrq, 0);
        checkOutput("ab_err", errOut, 0);
        stepCycle();
        checkOutput("ab_run2", stateOut, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("mid_drain", stateOut, 1);
        checkOutput("mid_wr", wrOut, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rstN = 1'b0;
        stepCycle();
        checkOutput("mid_rst_state", stateOut, 2);
        checkOutput("mid_rst_wr", wrOut, 0);
        checkOutput("mid_rst_ack", isoAck, 1);
        checkOutput("mid_rst_irq", timeoutIrq, 0);
        rstN = 1'b1;
        stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
